mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that serializes icache reads, dcache reads and dcache
// writes onto one memory read/write channel pair, with a completion watchdog.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_icache_read_req,
  input  logic [ADDR_WIDTH-1:0] i_icache_read_address,
  output logic [LINE_WIDTH-1:0] o_icache_cache_line,
  output logic                  o_icache_read_done,
  input  logic                  i_dcache_read_req,
  input  logic [ADDR_WIDTH-1:0] i_dcache_read_address,
  output logic [LINE_WIDTH-1:0] o_dcache_cache_line,
  output logic                  o_dcache_read_done,
  input  logic                  i_dcache_write_valid,
  input  logic [ADDR_WIDTH-1:0] i_dcache_write_address,
  input  logic [DATA_WIDTH-1:0] i_dcache_write_data,
  input  logic [7:0]            i_dcache_write_strobe,
  output logic                  o_dcache_write_done,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH-1:0] o_mem_read_address,
  input  logic                  i_mem_read_done,
  input  logic [LINE_WIDTH-1:0] i_cache_line,
  output logic                  o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_write_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic [7:0]            o_write_strobe,
  input  logic                  i_mem_write_done,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  // Handshake: a cache holds its request until its done pulse; the memory
  // sees req/valid high with stable address/data/strobe until its done.
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] REQ_WR  = 2'd0;
  localparam logic [1:0] REQ_DRD = 2'd1;
  localparam logic [1:0] REQ_IRD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RECOVER} state_t;

  state_t          r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_owner;
  logic [WDW-1:0]  r_wdog;

  logic [2:0]            w_req;
  logic [1:0]            w_c0, w_c1, w_c2;
  logic [1:0]            w_sel;
  logic                  w_any;
  logic                  w_wd_expired;
  logic [LINE_WIDTH-1:0] w_fill_line;

  function automatic logic [1:0] f_next(input logic [1:0] g);
    return (g == REQ_IRD) ? REQ_WR : g + 2'd1;
  endfunction

  assign w_req        = {i_icache_read_req, i_dcache_read_req, i_dcache_write_valid};
  assign w_any        = |w_req;
  assign w_wd_expired = (r_wdog == WD_LAST);
  // A watchdog abort returns an all-zero line to the owner.
  assign w_fill_line  = i_mem_read_done ? i_cache_line : '0;

  always_comb begin
    w_c0  = f_next(r_last);
    w_c1  = f_next(w_c0);
    w_c2  = f_next(w_c1);
    w_sel = w_req[w_c0] ? w_c0 : (w_req[w_c1] ? w_c1 : w_c2);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state             <= S_IDLE;
      r_last              <= REQ_IRD;
      r_owner             <= REQ_WR;
      r_wdog              <= '0;
      o_icache_cache_line <= '0;
      o_icache_read_done  <= 1'b0;
      o_dcache_cache_line <= '0;
      o_dcache_read_done  <= 1'b0;
      o_dcache_write_done <= 1'b0;
      o_mem_read_req      <= 1'b0;
      o_mem_read_address  <= '0;
      o_mem_write_valid   <= 1'b0;
      o_mem_write_address <= '0;
      o_mem_write_data    <= '0;
      o_write_strobe      <= '0;
      o_busy              <= 1'b0;
      o_timeout_err       <= 1'b0;
    end else begin
      o_icache_read_done  <= 1'b0;
      o_dcache_read_done  <= 1'b0;
      o_dcache_write_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_wdog  <= '0;
            o_busy  <= 1'b1;
            if (w_sel == REQ_WR) begin
              o_mem_write_address <= i_dcache_write_address;
              o_mem_write_data    <= i_dcache_write_data;
              o_write_strobe      <= i_dcache_write_strobe;
              o_mem_write_valid   <= 1'b1;
              r_state             <= S_WR;
            end else begin
              o_mem_read_address <= (w_sel == REQ_DRD) ? i_dcache_read_address
                                                       : i_icache_read_address;
              o_mem_read_req     <= 1'b1;
              r_state            <= S_RD;
            end
          end
        end
        S_RD: begin
          if (i_mem_read_done || w_wd_expired) begin
            o_mem_read_req <= 1'b0;
            r_state        <= S_RECOVER;
            if (!i_mem_read_done) o_timeout_err <= 1'b1;
            if (r_owner == REQ_DRD) begin
              o_dcache_cache_line <= w_fill_line;
              o_dcache_read_done  <= 1'b1;
            end else begin
              o_icache_cache_line <= w_fill_line;
              o_icache_read_done  <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_WR: begin
          if (i_mem_write_done || w_wd_expired) begin
            o_mem_write_valid   <= 1'b0;
            o_dcache_write_done <= 1'b1;
            r_state             <= S_RECOVER;
            if (!i_mem_write_done) o_timeout_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RECOVER: begin
          // Owner is still dropping its request this cycle; ignore everything.
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: cache clients, a memory responder
// and a transaction-level reference model stepped once per clock.
module tb_mem_req_arbiter;
  localparam int AW = 64, DW = 64, LW = 256, TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]    pend;
  logic [AW-1:0] c_addr [3];
  logic [DW-1:0] c_wdata;
  logic [7:0]    c_strb;
  logic          mem_rd_done, mem_wr_done;
  logic [LW-1:0] mem_line;

  logic [LW-1:0] o_icache_cache_line, o_dcache_cache_line;
  logic          o_icache_read_done, o_dcache_read_done, o_dcache_write_done;
  logic          o_mem_read_req, o_mem_write_valid, o_busy, o_timeout_err;
  logic [AW-1:0] o_mem_read_address, o_mem_write_address;
  logic [DW-1:0] o_mem_write_data;
  logic [7:0]    o_write_strobe;

  mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_icache_read_req(pend[2]), .i_icache_read_address(c_addr[2]),
    .o_icache_cache_line(o_icache_cache_line), .o_icache_read_done(o_icache_read_done),
    .i_dcache_read_req(pend[1]), .i_dcache_read_address(c_addr[1]),
    .o_dcache_cache_line(o_dcache_cache_line), .o_dcache_read_done(o_dcache_read_done),
    .i_dcache_write_valid(pend[0]), .i_dcache_write_address(c_addr[0]),
    .i_dcache_write_data(c_wdata), .i_dcache_write_strobe(c_strb),
    .o_dcache_write_done(o_dcache_write_done),
    .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
    .i_mem_read_done(mem_rd_done), .i_cache_line(mem_line),
    .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
    .o_mem_write_data(o_mem_write_data), .o_write_strobe(o_write_strobe),
    .i_mem_write_done(mem_wr_done), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0, n_fail = 0;
  logic [1:0] exp_q[$];          // owners of granted, not yet completed transactions
  int grant_log[$];
  int model_last = 2;            // requester order 0=WR, 1=DRD, 2=IRD
  int lat_lo = 1, lat_hi = 1, cur_lat = 0, hi_cnt = 0;
  int rearm_wait [3] = '{0, 0, 0};
  bit rearm [3] = '{0, 0, 0};
  bit responded = 0, prev_act = 0, model_idle = 1, exp_err = 0, stray_en = 0, line_fixed = 0;
  logic [LW-1:0] resp_line, exp_iline = '0, exp_dline = '0;

  task automatic check(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(logic [2:0] p, int last);
    for (int k = 1; k <= 3; k++) if (p[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic raise(int i);
    if (!pend[i]) begin
      c_addr[i] = {2'(i), 30'($urandom), 32'($urandom)};
      if (i == 0) begin
        c_wdata = {$urandom, $urandom};
        c_strb  = 8'($urandom);
      end
      pend[i] = 1'b1;
    end
  endtask

  // One clock: observe at the falling edge, check, then drive the next inputs.
  task automatic step();
    logic act, rise, fell, grant_due;
    int nd, own, dur, obs_own;
    logic [1:0] e_own;
    logic [LW-1:0] line_exp;
    grant_due = model_idle && (pend != 3'b000);
    @(negedge clk);
    act  = o_mem_read_req | o_mem_write_valid;
    rise = act & ~prev_act;
    fell = ~act & prev_act;
    nd   = int'(o_icache_read_done) + int'(o_dcache_read_done) + int'(o_dcache_write_done);
    check("grant_timing", rise, grant_due);
    check("busy", o_busy, act | (nd != 0));
    check("done_at_req_drop", nd != 0, fell);
    check("one_channel", o_mem_read_req & o_mem_write_valid, 1'b0);
    if (rise) begin
      own = model_pick(pend, model_last);
      check("grant_had_request", own >= 0, 1'b1);
      if (own >= 0) begin
        check("grant_is_write", o_mem_write_valid, own == 0);
        check("grant_addr", o_mem_write_valid ? o_mem_write_address : o_mem_read_address, c_addr[own]);
        if (own == 0) begin
          check("write_data", o_mem_write_data, c_wdata);
          check("write_strobe", o_write_strobe, c_strb);
        end
        exp_q.push_back(2'(own));
        grant_log.push_back(own);
        model_last = own;
      end
      cur_lat = $urandom_range(lat_lo, lat_hi);
      hi_cnt = 0;
      responded = 0;
    end
    if (fell) begin
      dur = (cur_lat >= 1 && cur_lat <= TO) ? cur_lat : TO;
      check("req_duration", hi_cnt, dur);
    end
    if (nd != 0) begin
      check("done_onehot", nd, 1);
      obs_own = o_dcache_write_done ? 0 : (o_dcache_read_done ? 1 : 2);
      check("done_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e_own = exp_q.pop_front();
        check("done_owner", obs_own, e_own);
        line_exp = responded ? resp_line : '0;
        if (!responded) exp_err = 1;
        if (e_own == 2'd1) exp_dline = line_exp;
        if (e_own == 2'd2) exp_iline = line_exp;
        check("timeout_err", o_timeout_err, exp_err);
        pend[e_own] = 1'b0;
        if (rearm[e_own]) rearm_wait[e_own] = 2;
      end
    end
    check("icache_line", o_icache_cache_line, exp_iline);
    check("dcache_line", o_dcache_cache_line, exp_dline);
    // memory responder, with stray completions on the wrong channel
    mem_rd_done = 1'b0;
    mem_wr_done = 1'b0;
    if (act) hi_cnt++;
    if (act && hi_cnt == cur_lat) begin
      resp_line = line_fixed ? {32{8'hA5}} : {$urandom, $urandom, $urandom, $urandom,
                                              $urandom, $urandom, $urandom, $urandom};
      responded = 1;
      mem_line = resp_line;
      if (o_mem_read_req) mem_rd_done = 1'b1;
      else mem_wr_done = 1'b1;
    end else if (stray_en && $urandom_range(0, 3) == 0) begin
      mem_line = {8{$urandom}};
      if (!act || o_mem_write_valid) mem_rd_done = 1'b1;
      if (!act || o_mem_read_req) mem_wr_done = 1'b1;
    end
    prev_act = act;
    model_idle = !act && (nd == 0);
    for (int i = 0; i < 3; i++)
      if (rearm_wait[i] > 0) begin
        rearm_wait[i]--;
        if (rearm_wait[i] == 0) raise(i);
      end
  endtask

  task automatic wait_idle(int budget);
    bit done_ok = 0;
    for (int c = 0; c < budget && !done_ok; c++) begin
      step();
      done_ok = (pend == 3'b000) && (exp_q.size() == 0) && !prev_act;
    end
    check("idle_within_budget", done_ok, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    rst = 1'b1; pend = 3'b000; mem_rd_done = 1'b0; mem_wr_done = 1'b0; mem_line = '0;
    c_addr[0] = '0; c_addr[1] = '0; c_addr[2] = '0; c_wdata = '0; c_strb = '0;
    #1;
    check("rst_read_req", o_mem_read_req, 1'b0);
    check("rst_write_valid", o_mem_write_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_timeout_err, 1'b0);
    check("rst_done", {o_icache_read_done, o_dcache_read_done, o_dcache_write_done}, 3'b000);
    check("rst_read_addr", o_mem_read_address, '0);
    step(); step();
    rst = 1'b0;

    // single icache fill, 5-cycle memory, A5 pattern line
    lat_lo = 5; lat_hi = 5; line_fixed = 1;
    raise(2); c_addr[2] = 64'h1000;
    wait_idle(30);
    check("ird_line_a5", o_icache_cache_line, {32{8'hA5}});
    line_fixed = 0;

    // all three at once: WR, DRD, IRD
    lat_lo = 3; lat_hi = 3;
    raise(0); raise(1); raise(2);
    c_wdata = 64'hDEADBEEF; c_strb = 8'h0F;
    base = grant_log.size();
    wait_idle(60);
    check("order_wr", grant_log[base], 0);
    check("order_drd", grant_log[base + 1], 1);
    check("order_ird", grant_log[base + 2], 2);

    // fairness with continuous DRD + IRD
    lat_lo = 1; lat_hi = 4;
    rearm[1] = 1; rearm[2] = 1;
    base = grant_log.size();
    raise(1); raise(2);
    repeat (80) step();
    rearm[1] = 0; rearm[2] = 0;
    wait_idle(40);
    check("fair_enough_grants", grant_log.size() - base >= 8, 1'b1);
    check("fair_first_drd", grant_log[base], 1);
    for (int k = base + 1; k < grant_log.size(); k++)
      check("fair_alternate", grant_log[k] != grant_log[k - 1], 1'b1);

    // done on the same edge as watchdog expiry is a normal completion
    lat_lo = TO; lat_hi = TO;
    raise(2);
    wait_idle(30);
    check("expiry_tie_no_err", o_timeout_err, 1'b0);

    // no memory response: abort with zero line and sticky error
    lat_lo = 0; lat_hi = 0;
    raise(1);
    wait_idle(30);
    check("timeout_line_zero", o_dcache_cache_line, '0);
    lat_lo = 2; lat_hi = 2;
    raise(2);
    wait_idle(30);
    check("err_sticky", o_timeout_err, 1'b1);

    // randomized traffic with stray completions and mid-transaction drops
    stray_en = 1; lat_lo = 1; lat_hi = 10;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) == 0) raise(i);
      if (exp_q.size() != 0 && $urandom_range(0, 5) == 0) pend[exp_q[0]] = 1'b0;
      repeat ($urandom_range(0, 6)) step();
    end
    wait_idle(400);
    stray_en = 0;

    // reset in the middle of a write
    lat_lo = 0; lat_hi = 0;
    raise(0);
    for (int c = 0; c < 10 && !prev_act; c++) step();
    check("reached_wr", o_mem_write_valid, 1'b1);
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("midrst_write_valid", o_mem_write_valid, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_err", o_timeout_err, 1'b0);
    check("midrst_lines", {o_icache_cache_line, o_dcache_cache_line}, '0);
    exp_q.delete(); pend = 3'b000; model_last = 2; prev_act = 0; model_idle = 1;
    exp_err = 0; exp_iline = '0; exp_dline = '0; mem_rd_done = 1'b0; mem_wr_done = 1'b0;
    step(); step();
    rst = 1'b0;
    lat_lo = 2; lat_hi = 2;
    base = grant_log.size();
    raise(1); raise(0);
    wait_idle(40);
    check("post_rst_first_wr", grant_log[base], 0);
    check("post_rst_then_drd", grant_log[base + 1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
